// File: rtl/alu_multicycle.sv
// Registered ALU: one-cycle add/sub/branch, andb, xor; logical shifts run one bit per cycle
// under a start/busy/done handshake.
module alu_multicycle #(
   parameter int DATA_WIDTH  = 8,
   parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic [DATA_WIDTH-1:0] in2,
   input  logic [1:0]            alu_op,
   input  logic [1:0]            branch_sel,
   input  logic                  sub,
   input  logic                  branch,
   input  logic                  shift_left,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] out_val,
   output logic                  zero,
   output logic                  sign,
   output logic                  overflow
);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t state, state_next;

   logic signed [DATA_WIDTH-1:0] opa, opb, sum;
   logic [2:0]            flags_now;
   logic                  flag_sel;
   logic                  oversize;
   logic                  accept;
   logic                  multi;
   logic                  shift_last;
   logic [DATA_WIDTH-1:0] result_now;
   logic [DATA_WIDTH-1:0] shreg;
   logic [DATA_WIDTH-1:0] shifted;
   logic [SHAMT_WIDTH-1:0] cnt;
   logic                  dir;
   logic [2:0]            pend_flags;

   function automatic logic [2:0] adder_flags(input logic signed [DATA_WIDTH-1:0] a,
                                              input logic signed [DATA_WIDTH-1:0] b,
                                              input logic signed [DATA_WIDTH-1:0] s);
      logic ovf;
      ovf = (a[DATA_WIDTH-1] == b[DATA_WIDTH-1]) && (s[DATA_WIDTH-1] != a[DATA_WIDTH-1]);
      return {(s == '0), s[DATA_WIDTH-1], ovf};
   endfunction

   assign opa       = $signed(in1);
   assign opb       = $signed(sub ? ~in2 : in2);
   assign sum       = opa + opb + $signed({{(DATA_WIDTH-1){1'b0}}, sub});
   assign flags_now = adder_flags(opa, opb, sum);

   // Any bit at or above SHAMT_WIDTH means the whole operand shifts out.
   assign oversize   = |(in2 >> SHAMT_WIDTH);
   assign accept     = start && (state == IDLE);
   assign multi      = accept && (alu_op == 2'b11) && (in2 != '0) && !oversize;
   assign shift_last = (state == SHIFT) && (cnt == SHAMT_WIDTH'(1));
   assign shifted    = dir ? (shreg << 1) : (shreg >> 1);
   assign busy       = (state == SHIFT);

   always_comb begin
      flag_sel = flags_now[2];
      case (branch_sel)
         2'b01:   flag_sel = flags_now[1];
         2'b10:   flag_sel = flags_now[0];
         default: flag_sel = flags_now[2];
      endcase
   end

   always_comb begin
      result_now = '0;
      case (alu_op)
         2'b00:   result_now = branch ? {{(DATA_WIDTH-1){1'b0}}, flag_sel} : sum;
         2'b01:   result_now = in1 & {DATA_WIDTH{in2[0]}};
         2'b10:   result_now = in1 ^ in2;
         default: result_now = oversize ? '0 : in1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (multi)      state_next = SHIFT;
         SHIFT:   if (shift_last) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Shift working registers; only meaningful while in SHIFT.
   always_ff @(posedge clk) begin
      if (multi) begin
         shreg      <= in1;
         cnt        <= in2[SHAMT_WIDTH-1:0];
         dir        <= shift_left;
         pend_flags <= flags_now;
      end else if (state == SHIFT) begin
         shreg <= shifted;
         cnt   <= cnt - SHAMT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_val  <= '0;
         zero     <= 1'b0;
         sign     <= 1'b0;
         overflow <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept && !multi) begin
            out_val                 <= result_now;
            {zero, sign, overflow} <= flags_now;
            done                    <= 1'b1;
         end else if (shift_last) begin
            out_val                 <= shifted;
            {zero, sign, overflow} <= pend_flags;
            done                    <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed self-checking bench for alu_multicycle (8-bit instance plus a 16-bit instance).
module tb_alu_multicycle;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   logic       start, sub, branch, shift_left, busy, done, zero, sign, overflow;
   logic [7:0] in1, in2, out_val;
   logic [1:0] alu_op, branch_sel;

   logic        start16, busy16, done16, zero16, sign16, overflow16;
   logic [15:0] in1_16, in2_16, out16;

   always #5 clk = ~clk;

   alu_multicycle #(.DATA_WIDTH(8)) dut (
      .clk(clk), .reset(reset), .start(start), .in1(in1), .in2(in2),
      .alu_op(alu_op), .branch_sel(branch_sel), .sub(sub), .branch(branch),
      .shift_left(shift_left), .busy(busy), .done(done), .out_val(out_val),
      .zero(zero), .sign(sign), .overflow(overflow)
   );

   alu_multicycle #(.DATA_WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .start(start16), .in1(in1_16), .in2(in2_16),
      .alu_op(2'b11), .branch_sel(2'b00), .sub(1'b0), .branch(1'b0),
      .shift_left(1'b1), .busy(busy16), .done(done16), .out_val(out16),
      .zero(zero16), .sign(sign16), .overflow(overflow16)
   );

   // Drive one op across a single rising edge; returns in the cycle after that edge.
   task automatic issue(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic s, input logic br, input logic [1:0] bs, input logic sl);
      @(negedge clk);
      alu_op = op; in1 = a; in2 = b; sub = s; branch = br; branch_sel = bs; shift_left = sl;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      in1 = 8'h00; in2 = 8'h00;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      checks++; if (out_val !== 8'h00) begin errors++; $display("FAIL reset_out got %h want 00", out_val); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if ({zero, sign, overflow} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {zero, sign, overflow}); end
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (done !== 1'b0) begin errors++; $display("FAIL idle_done got %b want 0", done); end
      end
   endtask

   task automatic test_add_overflow();
      issue(2'b00, 8'h7F, 8'h01, 1'b0, 1'b0, 2'b00, 1'b0);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL add_done got %b want 1", done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL add_busy got %b want 0", busy); end
      checks++; if (out_val !== 8'h80) begin errors++; $display("FAIL add_out got %h want 80", out_val); end
      checks++; if ({zero, sign, overflow} !== 3'b011) begin errors++; $display("FAIL add_flags got %b want 011", {zero, sign, overflow}); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL add_done_pulse got %b want 0", done); end
      checks++; if (out_val !== 8'h80) begin errors++; $display("FAIL add_hold got %h want 80", out_val); end
   endtask

   task automatic test_sub_branch();
      issue(2'b00, 8'h05, 8'h05, 1'b1, 1'b0, 2'b00, 1'b0);
      checks++; if (out_val !== 8'h00) begin errors++; $display("FAIL sub_out got %h want 00", out_val); end
      checks++; if ({zero, sign, overflow} !== 3'b100) begin errors++; $display("FAIL sub_flags got %b want 100", {zero, sign, overflow}); end
      issue(2'b00, 8'h05, 8'h05, 1'b1, 1'b1, 2'b00, 1'b0);
      checks++; if (out_val !== 8'h01) begin errors++; $display("FAIL branch_zero got %h want 01", out_val); end
      // 0x7F+0x01 overflows: overflow select gives 1, sign select gives 1
      issue(2'b00, 8'h7F, 8'h01, 1'b0, 1'b1, 2'b10, 1'b0);
      checks++; if (out_val !== 8'h01) begin errors++; $display("FAIL branch_ovf got %h want 01", out_val); end
      issue(2'b00, 8'h01, 8'h02, 1'b0, 1'b1, 2'b01, 1'b0);
      checks++; if (out_val !== 8'h00) begin errors++; $display("FAIL branch_sign got %h want 00", out_val); end
      issue(2'b01, 8'hA5, 8'h02, 1'b0, 1'b0, 2'b00, 1'b0);
      checks++; if (out_val !== 8'h00) begin errors++; $display("FAIL andb0 got %h want 00", out_val); end
      checks++; if ({zero, sign, overflow} !== 3'b010) begin errors++; $display("FAIL andb_flags got %b want 010", {zero, sign, overflow}); end
      issue(2'b01, 8'hA5, 8'h03, 1'b0, 1'b0, 2'b00, 1'b0);
      checks++; if (out_val !== 8'hA5) begin errors++; $display("FAIL andb1 got %h want a5", out_val); end
   endtask

   task automatic test_shifts();
      int lat, bcnt;
      issue(2'b11, 8'h81, 8'h03, 1'b0, 1'b0, 2'b00, 1'b1);
      lat = 1; bcnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         if (out_val !== 8'hA5) begin errors++; checks++; $display("FAIL shl_early_out got %h want a5", out_val); end
         @(negedge clk); lat++;
      end
      checks++; if (lat !== 4) begin errors++; $display("FAIL shl_latency got %0d want 4", lat); end
      checks++; if (bcnt !== 3) begin errors++; $display("FAIL shl_busy_cycles got %0d want 3", bcnt); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL shl_busy_done got %b want 0", busy); end
      checks++; if (out_val !== 8'h08) begin errors++; $display("FAIL shl_out got %h want 08", out_val); end
      checks++; if ({zero, sign, overflow} !== 3'b010) begin errors++; $display("FAIL shl_flags got %b want 010", {zero, sign, overflow}); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL shl_done_pulse got %b want 0", done); end

      issue(2'b11, 8'h80, 8'h07, 1'b0, 1'b0, 2'b00, 1'b0);
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      checks++; if (lat !== 8) begin errors++; $display("FAIL shr_latency got %0d want 8", lat); end
      checks++; if (out_val !== 8'h01) begin errors++; $display("FAIL shr_out got %h want 01", out_val); end

      issue(2'b11, 8'hFF, 8'h08, 1'b0, 1'b0, 2'b00, 1'b1);
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL shift8_done got %b want 1", done); end
      checks++; if (out_val !== 8'h00) begin errors++; $display("FAIL shift8_out got %h want 00", out_val); end

      issue(2'b11, 8'h5A, 8'h00, 1'b0, 1'b0, 2'b00, 1'b1);
      checks++; if (done !== 1'b1 || out_val !== 8'h5A) begin errors++; $display("FAIL shift0 got done=%b out=%h want 1 5a", done, out_val); end
   endtask

   task automatic test_handshake();
      int lat;
      issue(2'b11, 8'h81, 8'h03, 1'b0, 1'b0, 2'b00, 1'b1);
      // mid-shift start with an xor op must be ignored
      alu_op = 2'b10; in1 = 8'hFF; in2 = 8'h0F; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 2;
      while (done !== 1'b1 && lat < 40) begin @(negedge clk); lat++; end
      checks++; if (lat !== 4) begin errors++; $display("FAIL midstart_latency got %0d want 4", lat); end
      checks++; if (out_val !== 8'h08) begin errors++; $display("FAIL midstart_out got %h want 08", out_val); end
      // back-to-back: start accepted in the done cycle
      alu_op = 2'b10; in1 = 8'hF0; in2 = 8'h3C; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++; if (done !== 1'b1) begin errors++; $display("FAIL b2b_done got %b want 1", done); end
      checks++; if (out_val !== 8'hCC) begin errors++; $display("FAIL b2b_out got %h want cc", out_val); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL b2b_no_extra got %b want 0", done); end
   endtask

   task automatic test_reset_mid_shift();
      int seen;
      issue(2'b11, 8'hC3, 8'h05, 1'b0, 1'b0, 2'b00, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", busy); end
      checks++; if (out_val !== 8'h00) begin errors++; $display("FAIL rst_mid_out got %h want 00", out_val); end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (done === 1'b1 || busy === 1'b1) seen++;
         @(negedge clk);
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rst_mid_activity got %0d want 0", seen); end
   endtask

   task automatic test_wide();
      int lat;
      @(negedge clk);
      in1_16 = 16'h0001; in2_16 = 16'd15; start16 = 1'b1;
      @(negedge clk);
      start16 = 1'b0;
      lat = 1;
      while (done16 !== 1'b1 && lat < 60) begin @(negedge clk); lat++; end
      checks++; if (lat !== 16) begin errors++; $display("FAIL w16_latency got %0d want 16", lat); end
      checks++; if (out16 !== 16'h8000) begin errors++; $display("FAIL w16_out got %h want 8000", out16); end
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; in1 = '0; in2 = '0; alu_op = '0; branch_sel = '0;
      sub = 1'b0; branch = 1'b0; shift_left = 1'b0;
      start16 = 1'b0; in1_16 = '0; in2_16 = '0;
      test_reset();
      test_add_overflow();
      test_sub_branch();
      test_shifts();
      test_handshake();
      test_reset_mid_shift();
      test_wide();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
